// File: rtl/lbus_cycle_sequencer.sv
// rtl/lbus_cycle_sequencer.sv - 68040 local-bus transfer to DSACK-terminated port cycle sequencer
module lbus_cycle_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic       CLK40,
    input  logic       nRESET,
    input  logic       nTS_CPU,
    input  logic       RnW,
    input  logic [1:0] SIZ,
    input  logic [1:0] A,
    input  logic [1:0] A32,
    input  logic [1:0] DSACK,
    input  logic       nTBI,
    input  logic       nTCI,
    output logic       nTS,
    output logic       nTA,
    output logic       nTEA,
    output logic       nTBI_CPU,
    output logic       nTCI_CPU,
    output logic [3:0] nBE,
    output logic [3:0] AOUT,
    output logic       SWAP,
    output logic       LAT_EN,
    output logic       BUSY
);
    typedef enum logic [2:0] {IDLE, START, WAIT, ACK, RECOVER} state_t;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_LINE = 2'b11;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t         state, state_nxt;
    logic           rnw_q;
    logic [1:0]     siz_q;
    logic [1:0]     a_q;
    logic [1:0]     beat_a32;
    logic [1:0]     beats_left;
    logic           second_half;
    logic           beat_done_q;
    logic           tbi_seen;
    logic           tci_q;
    logic           swap_q;
    logic           tea_q;
    logic [WDW-1:0] wd_cnt;

    logic           is_wide;
    logic           ack_any;
    logic           wd_expired;
    logic [3:0]     lanes;

    assign is_wide    = (siz_q == SIZ_LONG) || (siz_q == SIZ_LINE);
    assign ack_any    = (DSACK != 2'b11);
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    // Lane enables of the first subcycle of a beat, from captured size and offset
    always_comb begin
        lanes = 4'b0000;
        if (siz_q == SIZ_BYTE) begin
            case (a_q)
                2'b00:   lanes = 4'b0111;
                2'b01:   lanes = 4'b1011;
                2'b10:   lanes = 4'b1101;
                default: lanes = 4'b1110;
            endcase
        end else if (!is_wide) begin
            lanes = a_q[1] ? 4'b1100 : 4'b0011;
        end
    end

    // State register
    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode; a beat is finished once its last subcycle acks,
    // the line stops early when burst inhibit was seen on the first beat
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!nTS_CPU) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (ack_any)         state_nxt = ACK;
                else if (wd_expired) state_nxt = IDLE;
            end
            ACK:     state_nxt = RECOVER;
            RECOVER: begin
                if (!ack_any) begin
                    if (!beat_done_q || ((beats_left != 2'd0) && !tbi_seen))
                        state_nxt = START;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state and transfer context
    always_comb begin
        nTS      = (state != START);
        nTA      = !((state == ACK) && beat_done_q);
        LAT_EN   = (state == ACK) && rnw_q;
        nTCI_CPU = ((state == ACK) && beat_done_q) ? tci_q : 1'b1;
        nTBI_CPU = !((state == ACK) && beat_done_q && tbi_seen);
        nTEA     = !tea_q;
        BUSY     = (state != IDLE);
        SWAP     = (state != IDLE) && (second_half || swap_q);
        if (state == IDLE) begin
            nBE  = 4'hF;
            AOUT = 4'h0;
        end else begin
            nBE  = second_half ? 4'b1100 : lanes;
            AOUT = {beat_a32, second_half ? 2'b10 : (is_wide ? 2'b00 : a_q)};
        end
    end

    // Transfer capture, beat/subcycle bookkeeping, ack sampling and watchdog
    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            rnw_q       <= 1'b0;
            siz_q       <= 2'b00;
            a_q         <= 2'b00;
            beat_a32    <= 2'b00;
            beats_left  <= 2'b00;
            second_half <= 1'b0;
            beat_done_q <= 1'b0;
            tbi_seen    <= 1'b0;
            tci_q       <= 1'b1;
            swap_q      <= 1'b0;
            tea_q       <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            tea_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!nTS_CPU) begin
                        rnw_q       <= RnW;
                        siz_q       <= SIZ;
                        a_q         <= A;
                        beat_a32    <= A32;
                        beats_left  <= (SIZ == SIZ_LINE) ? 2'd3 : 2'd0;
                        second_half <= 1'b0;
                        beat_done_q <= 1'b0;
                        tbi_seen    <= 1'b0;
                        swap_q      <= 1'b0;
                    end
                end
                START: wd_cnt <= '0;
                WAIT: begin
                    if (ack_any) begin
                        // A 16-bit ack on the low half of a longword needs a second subcycle
                        beat_done_q <= !(is_wide && !second_half && (DSACK == 2'b01));
                        tci_q       <= nTCI;
                        if ((siz_q == SIZ_LINE) && (beats_left == 2'd3) && !second_half && !nTBI)
                            tbi_seen <= 1'b1;
                        if ((DSACK == 2'b01) && !is_wide && a_q[1])
                            swap_q <= 1'b1;
                    end else if (wd_expired) begin
                        tea_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    if (!ack_any) begin
                        swap_q <= 1'b0;
                        if (beat_done_q) begin
                            second_half <= 1'b0;
                            if (beats_left != 2'd0) begin
                                beat_a32   <= beat_a32 + 2'd1;
                                beats_left <= beats_left - 2'd1;
                            end
                        end else begin
                            second_half <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
